// File: rtl/data_sram_pkg.sv
// Shared types and helpers for the data_sram responder.
//   WORD_W      - data word width
//   LANES       - number of byte lanes per word
//   rd_stage_t  - one slot of the read-return pipe
//   lane_merge  - byte-lane write merge of a new word into an old word
package data_sram_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [WORD_W-1:0] data;
  } rd_stage_t;

  // Lane i of the result comes from wdata when we[i] is set, otherwise from old_w.
  function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] wdata,
                                                   input logic [LANES-1:0]  we);
    logic [WORD_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipe: delays a launched read by DEPTH cycles and drives the
// responder outputs from the last stage. The output registers count as the
// final stage, so DEPTH=1 has no stages besides them.
//   clk, resetn  - clock, asynchronous active-low reset
//   launch_i     - read launched this cycle {valid, err, data}
//   rdata_o      - data of the last returned read (holds between reads)
//   valid_o      - pulses with each returned read
//   err_o        - pulses with valid_o when that read was out of window
module sram_rd_pipe
  import data_sram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  rd_stage_t         launch_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              valid_o,
  output logic              err_o
);

  rd_stage_t tail;

  if (DEPTH > 1) begin : g_chain
    rd_stage_t stg_q [DEPTH-1];

    // NOTE: sequential state always uses non-blocking assignments so that every
    // stage samples its predecessor's value from before the edge.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < DEPTH-1; i++) stg_q[i] <= '0;
      end else begin
        stg_q[0] <= launch_i;
        for (int i = 1; i < DEPTH-1; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign tail = stg_q[DEPTH-2];
  end else begin : g_direct
    assign tail = launch_i;
  end

  logic [WORD_W-1:0] rdata_q;
  logic              valid_q;
  logic              err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= tail.valid;
      err_q   <= tail.valid & tail.err;
      if (tail.valid) rdata_q <= tail.data;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/data_sram_resp.sv
// Responder for the data_sram request interface: single-port word RAM with
// byte-lane writes and read-first semantics, read data returned READ_LAT
// cycles after the request, plus read/write access counters and an
// out-of-window error flag.
//   clk, resetn        - clock, asynchronous active-low reset
//   data_sram_en       - request valid this cycle
//   data_sram_we       - byte-lane write enables (0 = read)
//   data_sram_addr     - byte address, bits [1:0] ignored
//   data_sram_wdata    - write data
//   data_sram_rdata    - read data, READ_LAT cycles after request
//   rdata_valid        - pulses with each returned read
//   addr_err           - pulses with rdata_valid for out-of-window requests
//   rd_cnt / wr_cnt    - wrapping counts of read / write requests
module data_sram_resp
  import data_sram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          READ_LAT   = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [WORD_W-1:0] data_sram_wdata,
  output logic [WORD_W-1:0] data_sram_rdata,
  output logic              rdata_valid,
  output logic              addr_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("data_sram_resp: READ_LAT must be 1..3");
  end

  logic [WORD_W-1:0] mem_q [WORDS];

  // Window decode: anything at or above 2^(DEPTH_LOG2+2) bytes past the base,
  // including addresses below the base (they wrap to large offsets), is outside.
  logic [31:0]           offset;
  logic                  in_win;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_write;

  assign offset   = data_sram_addr - BASE_ADDR;
  assign in_win   = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = offset[DEPTH_LOG2+1:2];
  assign is_write = |data_sram_we;

  // NOTE: the array has no reset; its contents survive resetn so data written
  // before a reset is still readable afterwards.
  always_ff @(posedge clk) begin
    if (data_sram_en && is_write && in_win) begin
      mem_q[idx] <= lane_merge(mem_q[idx], data_sram_wdata, data_sram_we);
    end
  end

  // The launched read samples the array before this edge's write: read-first.
  rd_stage_t launch;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    launch       = '0;
    launch.valid = data_sram_en;
    launch.err   = ~in_win;
    launch.data  = in_win ? mem_q[idx] : '0;
  end

  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (data_sram_en) begin
      if (is_write) wr_cnt_d = wr_cnt_q + 32'd1;
      else          rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

  sram_rd_pipe #(
    .DEPTH(READ_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .launch_i(launch),
    .rdata_o (data_sram_rdata),
    .valid_o (rdata_valid),
    .err_o   (addr_err)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: two instances (READ_LAT=1 and READ_LAT=3) share
// one stimulus stream; a transaction-level model (associative memory, access
// counts, a short history of returned reads) predicts every output cycle.
module tb_data_sram_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DL2  = 16;
  localparam logic [31:0] WIN  = 32'h1 << (DL2 + 2);

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata1, rd_cnt1, wr_cnt1;
  logic        valid1, err1;
  logic [31:0] rdata3, rd_cnt3, wr_cnt3;
  logic        valid3, err3;

  data_sram_resp #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE), .READ_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
    .rdata_valid(valid1), .addr_err(err1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  data_sram_resp #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE), .READ_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
    .rdata_valid(valid3), .addr_err(err3), .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", phase, tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd, ref_wr;
  rsp_t        hist [3];          // hist[k]: read launched k+1 edges ago
  logic [31:0] exp_rd1, exp_rd3;  // last returned data per latency

  task automatic model_reset();
    ref_rd  = '0;
    ref_wr  = '0;
    exp_rd1 = '0;
    exp_rd3 = '0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endtask

  task automatic model_edge();
    rsp_t        r;
    logic [31:0] off, mask, old;
    int          key;
    r = '0;
    if (en) begin
      off  = addr - BASE;
      key  = int'(off >> 2);
      r.v  = 1'b1;
      r.e  = !(off < WIN);
      r.d  = (off < WIN) ? ref_mem[key] : 32'h0;
      if (we != 4'h0) ref_wr = ref_wr + 1;
      else            ref_rd = ref_rd + 1;
      if (we != 4'h0 && off < WIN) begin
        old  = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        ref_mem[key] = (old & ~mask) | (wdata & mask);
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = r;
    if (hist[0].v) exp_rd1 = hist[0].d;
    if (hist[2].v) exp_rd3 = hist[2].d;
  endtask

  task automatic compare_all();
    check("l1.valid", 32'(valid1), 32'(hist[0].v));
    check("l1.err",   32'(err1),   32'(hist[0].v & hist[0].e));
    check("l1.rdata", rdata1,      exp_rd1);
    check("l1.rd_cnt", rd_cnt1,    ref_rd);
    check("l1.wr_cnt", wr_cnt1,    ref_wr);
    check("l3.valid", 32'(valid3), 32'(hist[2].v));
    check("l3.err",   32'(err3),   32'(hist[2].v & hist[2].e));
    check("l3.rdata", rdata3,      exp_rd3);
    check("l3.rd_cnt", rd_cnt3,    ref_rd);
    check("l3.wr_cnt", wr_cnt3,    ref_wr);
  endtask

  // One request cycle: drive, clock, update model, sample 1 time unit later.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Asynchronous reset pulse, asserted away from any clock edge.
  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] pool_off(input int i);
    return (i < 16) ? 32'(i * 4) : (WIN - 32'd4);
  endfunction

  initial begin
    logic [31:0] a;
    int          sel;
    en     = 1'b0;
    we     = 4'h0;
    addr   = 32'h0;
    wdata  = 32'h0;
    resetn = 1'b1;
    model_reset();
    #2;

    phase = "reset";
    pulse_reset();

    phase = "preload";
    for (int i = 0; i < 17; i++) step(1'b1, 4'hF, BASE + pool_off(i), $urandom);

    phase = "basic_rw";
    step(1'b1, 4'hF, BASE + 32'h10, 32'h1122_3344);
    step(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    idle(3);

    phase = "lanes";
    step(1'b1, 4'hF, BASE + 32'h20, 32'hAABB_CCDD);
    step(1'b1, 4'b0010, BASE + 32'h20, 32'h0000_5500);
    step(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    step(1'b1, 4'b1100, BASE + 32'h20, 32'h1234_1234);
    step(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    idle(3);

    phase = "read_first";
    step(1'b1, 4'hF, BASE + 32'h30, 32'h0000_0001);
    idle(3);
    step(1'b1, 4'hF, BASE + 32'h30, 32'h0000_0002);
    step(1'b1, 4'h0, BASE + 32'h30, 32'h0);
    idle(3);

    phase = "window";
    step(1'b1, 4'hF, BASE, 32'hCAFE_0000);
    step(1'b1, 4'hF, BASE + WIN, 32'hDEAD_BEEF);
    step(1'b1, 4'h0, BASE, 32'h0);
    step(1'b1, 4'h0, BASE - 32'd4, 32'h0);
    step(1'b1, 4'h0, BASE + WIN - 32'd4, 32'h0);
    step(1'b1, 4'hF, BASE + WIN + 32'h10, 32'h5555_5555);
    step(1'b1, 4'h0, BASE + WIN - 32'd4, 32'h0);
    idle(3);

    phase = "stream";
    for (int i = 0; i < 8; i++) step(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    phase = "mid_reset";
    pulse_reset();
    phase = "post_reset";
    for (int i = 0; i < 8; i++) step(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    idle(3);

    phase = "random";
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 20));
      if (sel < 17)       a = BASE + pool_off(sel);
      else if (sel == 17) a = BASE + WIN + 32'($urandom_range(0, 15) * 4);
      else if (sel == 18) a = BASE - 32'd4;
      else                a = $urandom;
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 4'($urandom), $urandom, $urandom);
      else if (sel >= 19)
        step(1'b1, 4'h0, a, $urandom);
      else
        step(1'b1, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
             a, $urandom);
    end
    idle(3);

    phase = "wrap";
    force dut1.rd_cnt_q = 32'hFFFF_FFFE;
    force dut3.rd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut1.rd_cnt_q;
    release dut3.rd_cnt_q;
    ref_rd = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    check("l1.rd_cnt_wrapped", rd_cnt1, 32'h0000_0001);
    check("l3.rd_cnt_wrapped", rd_cnt3, 32'h0000_0001);

    phase = "en_low";
    for (int i = 0; i < 4; i++) step(1'b0, 4'hF, BASE + 32'(i * 4), 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
